// File: rtl/tetris_pkg.sv
// Shared types and constants for the active-piece controller.
package tetris_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DECLINE,
    S_STEAL
  } state_e;

  typedef enum logic [2:0] {
    P_I, P_O, P_J, P_L, P_S, P_T, P_Z
  } piece_e;

  localparam logic [1:0] INT_GRAV   = 2'd0;
  localparam logic [1:0] INT_PLAYER = 2'd1;
  localparam logic [1:0] INT_DROP   = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hF0;

  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_ROT  = 2;
  localparam int BTN_DROP = 3;

  // Fibonacci form, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(
    input logic [7:0] l
  );
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic piece_e pick_type(
    input logic [7:0] l
  );
    return (l[2:0] == 3'd7) ? P_I : piece_e'(l[2:0]);
  endfunction

endpackage

// File: rtl/piece_shaper.sv
// Block offsets inside the 4x4 piece box for every type and rotation.
module piece_shaper
  import tetris_pkg::*;
(
  input  logic [2:0] ptype,
  input  logic [1:0] rot,
  output logic [7:0] off_v,
  output logic [7:0] off_h
);

  // arguments are blocks 0..3, block 0 lands in the LSBs
  function automatic logic [7:0] p(
    input int a, input int b,
    input int c, input int d
  );
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  always_comb begin
    off_v = '0;
    off_h = '0;
    unique case (ptype)
      P_I: unique case (rot)
        2'd0: begin off_v = p(0,1,2,3); off_h = p(1,1,1,1); end
        2'd1: begin off_v = p(2,2,2,2); off_h = p(0,1,2,3); end
        2'd2: begin off_v = p(0,1,2,3); off_h = p(2,2,2,2); end
        2'd3: begin off_v = p(1,1,1,1); off_h = p(0,1,2,3); end
      endcase
      P_O: begin off_v = p(1,2,1,2); off_h = p(0,0,1,1); end
      P_J: unique case (rot)
        2'd0: begin off_v = p(0,0,1,2); off_h = p(0,1,1,1); end
        2'd1: begin off_v = p(1,2,1,1); off_h = p(0,0,1,2); end
        2'd2: begin off_v = p(0,1,2,2); off_h = p(1,1,1,2); end
        2'd3: begin off_v = p(1,1,0,1); off_h = p(0,1,2,2); end
      endcase
      P_L: unique case (rot)
        2'd0: begin off_v = p(2,0,1,2); off_h = p(0,1,1,1); end
        2'd1: begin off_v = p(1,1,1,2); off_h = p(0,1,2,2); end
        2'd2: begin off_v = p(0,1,2,0); off_h = p(1,1,1,2); end
        2'd3: begin off_v = p(0,1,1,1); off_h = p(0,0,1,2); end
      endcase
      P_S: unique case (rot)
        2'd0: begin off_v = p(1,2,0,1); off_h = p(0,0,1,1); end
        2'd1: begin off_v = p(1,1,2,2); off_h = p(0,1,1,2); end
        2'd2: begin off_v = p(1,2,0,1); off_h = p(1,1,2,2); end
        2'd3: begin off_v = p(0,0,1,1); off_h = p(0,1,1,2); end
      endcase
      P_T: unique case (rot)
        2'd0: begin off_v = p(1,0,1,2); off_h = p(0,1,1,1); end
        2'd1: begin off_v = p(1,1,2,1); off_h = p(0,1,1,2); end
        2'd2: begin off_v = p(0,1,2,1); off_h = p(1,1,1,2); end
        2'd3: begin off_v = p(1,0,1,1); off_h = p(0,1,1,2); end
      endcase
      P_Z: unique case (rot)
        2'd0: begin off_v = p(0,1,1,2); off_h = p(0,0,1,1); end
        2'd1: begin off_v = p(2,1,2,1); off_h = p(0,1,1,2); end
        2'd2: begin off_v = p(0,1,1,2); off_h = p(1,1,2,2); end
        2'd3: begin off_v = p(1,0,1,0); off_h = p(0,1,1,2); end
      endcase
      default: begin
        off_v = '0;
        off_h = '0;
      end
    endcase
  end

endmodule

// File: rtl/active_piece_ctrl.sv
// Active tetromino controller: debounced buttons, move proposals to the
// collision checker, verdict handling, hard drop and piece spawning.
module active_piece_ctrl
  import tetris_pkg::*;
#(
  parameter int COORD_W = 5,
  parameter int DEB_LEN = 6,
  parameter int SPAWN_V = 5,
  parameter int SPAWN_H = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gametick,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_rot,
  input  logic                 btn_drop,
  output logic                 mv_request,
  output logic [1:0]           mv_intent,
  input  logic                 mv_commit,
  input  logic                 mv_declined,
  input  logic                 mv_steal,
  output logic [4*COORD_W-1:0] blk_v,
  output logic [4*COORD_W-1:0] blk_h,
  output logic [2:0]           piece_type,
  output logic [2:0]           blk_color
);

  localparam logic [COORD_W-1:0] SP_V = COORD_W'(SPAWN_V);
  localparam logic [COORD_W-1:0] SP_H = COORD_W'(SPAWN_H);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  state_e state_q, state_d;
  logic [COORD_W-1:0] av_q, av_d;
  logic [COORD_W-1:0] ah_q, ah_d;
  logic [COORD_W-1:0] sv_q, sv_d;
  logic [COORD_W-1:0] sh_q, sh_d;
  logic [1:0] rot_q, rot_d;
  logic [1:0] srot_q, srot_d;
  piece_e type_q, type_d;
  logic [1:0] intent_q, intent_d;
  logic pend_q, pend_d;
  logic drop_q, drop_d;
  logic cool_q, cool_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0][DEB_LEN-1:0] deb_q, deb_d;

  logic [3:0] btn_raw;
  logic [3:0] press;
  logic btn_ok;
  logic [7:0] off_v, off_h;

  assign btn_raw = {btn_drop, btn_rot, btn_right, btn_left};

  piece_shaper u_shaper (
    .ptype (type_q),
    .rot   (rot_q),
    .off_v (off_v),
    .off_h (off_h)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      av_q     <= SP_V;
      ah_q     <= SP_H;
      sv_q     <= SP_V;
      sh_q     <= SP_H;
      rot_q    <= 2'd0;
      srot_q   <= 2'd0;
      type_q   <= P_T;
      intent_q <= INT_GRAV;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
      cool_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      deb_q    <= '0;
    end else begin
      state_q  <= state_d;
      av_q     <= av_d;
      ah_q     <= ah_d;
      sv_q     <= sv_d;
      sh_q     <= sh_d;
      rot_q    <= rot_d;
      srot_q   <= srot_d;
      type_q   <= type_d;
      intent_q <= intent_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      cool_q   <= cool_d;
      lfsr_q   <= lfsr_d;
      deb_q    <= deb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    av_d     = av_q;
    ah_d     = ah_q;
    sv_d     = sv_q;
    sh_d     = sh_q;
    rot_d    = rot_q;
    srot_d   = srot_q;
    type_d   = type_q;
    intent_d = intent_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    cool_d   = cool_q;
    lfsr_d   = lfsr_next(lfsr_q);
    btn_ok   = !cool_q && !drop_q;
    for (int b = 0; b < 4; b++) begin
      deb_d[b] = {deb_q[b][DEB_LEN-2:0], btn_raw[b]};
      press[b] = &deb_q[b];
    end
    if (deb_q == '0) cool_d = 1'b0;
    if (state_q != S_IDLE && gametick) pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        if (gametick || pend_q) begin
          ah_d     = ah_q + ONE;
          intent_d = INT_GRAV;
          pend_d   = 1'b0;
        end else if (drop_q) begin
          ah_d     = ah_q + ONE;
          intent_d = INT_DROP;
        end else if (btn_ok && press[BTN_DROP]) begin
          ah_d     = ah_q + ONE;
          intent_d = INT_DROP;
          drop_d   = 1'b1;
          cool_d   = 1'b1;
        end else if (btn_ok && press[BTN_L]) begin
          av_d     = av_q + ONE;
          intent_d = INT_PLAYER;
          cool_d   = 1'b1;
        end else if (btn_ok && press[BTN_R]) begin
          av_d     = av_q - ONE;
          intent_d = INT_PLAYER;
          cool_d   = 1'b1;
        end else if (btn_ok && press[BTN_ROT]) begin
          rot_d    = rot_q + 2'd1;
          intent_d = INT_PLAYER;
          cool_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mv_steal) begin
          state_d = S_STEAL;
          drop_d  = 1'b0;
        end else if (mv_declined) begin
          state_d = S_DECLINE;
          drop_d  = 1'b0;
        end else if (mv_commit) begin
          state_d = S_IDLE;
          sv_d    = av_q;
          sh_d    = ah_q;
          srot_d  = rot_q;
        end
      end
      S_DECLINE: begin
        if (!mv_declined) begin
          state_d = S_IDLE;
          av_d    = sv_q;
          ah_d    = sh_q;
          rot_d   = srot_q;
        end
      end
      S_STEAL: begin
        if (!mv_steal) begin
          state_d = S_IDLE;
          av_d    = SP_V;
          ah_d    = SP_H;
          rot_d   = 2'd0;
          sv_d    = SP_V;
          sh_d    = SP_H;
          srot_d  = 2'd0;
          pend_d  = 1'b0;
          type_d  = pick_type(lfsr_q);
        end
      end
    endcase
  end

  always_comb begin
    mv_request = (state_q == S_WAIT);
    mv_intent  = intent_q;
    piece_type = type_q;
    blk_color  = 3'(type_q) + 3'd1;
    blk_v      = '0;
    blk_h      = '0;
    for (int i = 0; i < 4; i++) begin
      blk_v[i*COORD_W +: COORD_W] = av_q + COORD_W'(off_v[2*i +: 2]);
      blk_h[i*COORD_W +: COORD_W] = ah_q + COORD_W'(off_h[2*i +: 2]);
    end
  end

endmodule

// File: tb/tb_active_piece_ctrl.sv
// Directed bench for active_piece_ctrl with hand-computed expectations.
module tb_active_piece_ctrl;

  logic clk;
  logic reset;
  logic gametick;
  logic btn_left, btn_right, btn_rot, btn_drop;
  logic mv_request;
  logic [1:0] mv_intent;
  logic mv_commit, mv_declined, mv_steal;
  logic [19:0] blk_v, blk_h;
  logic [2:0] piece_type, blk_color;

  int total = 0;
  int bad = 0;
  logic [7:0] m;
  logic [2:0] et;

  active_piece_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .gametick    (gametick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_rot     (btn_rot),
    .btn_drop    (btn_drop),
    .mv_request  (mv_request),
    .mv_intent   (mv_intent),
    .mv_commit   (mv_commit),
    .mv_declined (mv_declined),
    .mv_steal    (mv_steal),
    .blk_v       (blk_v),
    .blk_h       (blk_h),
    .piece_type  (piece_type),
    .blk_color   (blk_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference LFSR, taps 8,6,5,4, seed 0xF0
  always @(posedge clk) begin
    if (!reset) m <= 8'hF0;
    else m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] p(
    input int a, input int b,
    input int c, input int d
  );
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  // {h offsets, v offsets}; key = type*4 + rotation
  function automatic logic [15:0] shp(input int t, input int r);
    logic [7:0] ov;
    logic [7:0] oh;
    ov = '0;
    oh = '0;
    case (t * 4 + r)
      0:  begin ov = p(0,1,2,3); oh = p(1,1,1,1); end
      4:  begin ov = p(1,2,1,2); oh = p(0,0,1,1); end
      8:  begin ov = p(0,0,1,2); oh = p(0,1,1,1); end
      12: begin ov = p(2,0,1,2); oh = p(0,1,1,1); end
      16: begin ov = p(1,2,0,1); oh = p(0,0,1,1); end
      20: begin ov = p(1,0,1,2); oh = p(0,1,1,1); end
      21: begin ov = p(1,1,2,1); oh = p(0,1,1,2); end
      22: begin ov = p(0,1,2,1); oh = p(1,1,1,2); end
      23: begin ov = p(1,0,1,1); oh = p(0,1,1,2); end
      24: begin ov = p(0,1,1,2); oh = p(0,0,1,1); end
      default: ;
    endcase
    return {oh, ov};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_pos(
    input string tag, input int t, input int r,
    input int v, input int h
  );
    logic [15:0] o;
    logic [19:0] ev;
    logic [19:0] eh;
    o = shp(t, r);
    for (int i = 0; i < 4; i++) begin
      ev[i*5 +: 5] = 5'(v + int'(o[i*2 +: 2]));
      eh[i*5 +: 5] = 5'(h + int'(o[8 + i*2 +: 2]));
    end
    chk({tag, "_v"}, 32'(blk_v), 32'(ev));
    chk({tag, "_h"}, 32'(blk_h), 32'(eh));
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!mv_request && n < 40);
    chk(tag, 32'(mv_request), 1);
  endtask

  task automatic commit();
    mv_commit = 1'b1;
    step(1);
    mv_commit = 1'b0;
  endtask

  task automatic decline();
    mv_declined = 1'b1;
    step(1);
    mv_declined = 1'b0;
    step(1);
  endtask

  task automatic quiet(input string tag, input int n);
    int c = 0;
    repeat (n) begin
      step(1);
      if (mv_request) c++;
    end
    chk(tag, 32'(c), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    gametick = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_rot = 1'b0;
    btn_drop = 1'b0;
    mv_commit = 1'b0;
    mv_declined = 1'b0;
    mv_steal = 1'b0;
    step(3);
    chk("rst_req", 32'(mv_request), 0);
    chk("rst_intent", 32'(mv_intent), 0);
    chk("rst_type", 32'(piece_type), 5);
    chk("rst_color", 32'(blk_color), 6);
    chk_pos("rst_pos", 5, 0, 5, 0);
    reset = 1'b1;

    // verdicts outside a handshake do nothing
    mv_steal = 1'b1;
    mv_declined = 1'b1;
    step(1);
    mv_steal = 1'b0;
    mv_declined = 1'b0;
    step(2);
    chk("idle_verdict_req", 32'(mv_request), 0);
    chk("idle_verdict_type", 32'(piece_type), 5);
    chk_pos("idle_verdict_pos", 5, 0, 5, 0);

    // gravity: h 0 -> 1
    gametick = 1'b1;
    wait_req("tick_req");
    gametick = 1'b0;
    chk("tick_intent", 32'(mv_intent), 0);
    chk_pos("tick_pos", 5, 0, 5, 1);
    commit();
    chk("tick_commit_req", 32'(mv_request), 0);
    quiet("tick_idle", 3);

    // left held: one move only
    btn_left = 1'b1;
    step(6);
    chk("left_deb", 32'(mv_request), 0);
    wait_req("left_req");
    chk("left_intent", 32'(mv_intent), 1);
    chk_pos("left_pos", 5, 0, 6, 1);
    commit();
    quiet("left_hold", 20);
    chk_pos("left_hold_pos", 5, 0, 6, 1);
    btn_left = 1'b0;
    step(8);

    // cooldown cleared after release: right v 6 -> 5
    btn_right = 1'b1;
    wait_req("right_req");
    btn_right = 1'b0;
    chk_pos("right_pos", 5, 0, 5, 1);
    commit();
    step(8);

    // rotate 0 -> 3, then rotate to 0 and decline
    for (int k = 0; k < 3; k++) begin
      btn_rot = 1'b1;
      wait_req("rot_req");
      btn_rot = 1'b0;
      commit();
      step(8);
    end
    chk_pos("rot3_pos", 5, 3, 5, 1);
    btn_rot = 1'b1;
    wait_req("rot_wrap_req");
    btn_rot = 1'b0;
    chk_pos("rot_wrap_pos", 5, 0, 5, 1);
    decline();
    chk("rot_decl_req", 32'(mv_request), 0);
    chk_pos("rot_decl_pos", 5, 3, 5, 1);
    step(8);

    // tick during WAIT is served after commit
    gametick = 1'b1;
    wait_req("pend_req1");
    gametick = 1'b0;
    gametick = 1'b1;
    step(1);
    gametick = 1'b0;
    chk("pend_wait_req", 32'(mv_request), 1);
    commit();
    chk("pend_gap", 32'(mv_request), 0);
    step(1);
    chk("pend_req2", 32'(mv_request), 1);
    chk("pend_intent", 32'(mv_intent), 0);
    chk_pos("pend_pos", 5, 3, 5, 3);
    commit();
    quiet("pend_once", 5);

    // hard drop: three commits then decline
    btn_drop = 1'b1;
    wait_req("drop_req");
    btn_drop = 1'b0;
    chk("drop_intent", 32'(mv_intent), 2);
    chk_pos("drop_pos", 5, 3, 5, 4);
    for (int k = 0; k < 3; k++) begin
      commit();
      step(1);
      chk("drop_auto_req", 32'(mv_request), 1);
      chk("drop_auto_intent", 32'(mv_intent), 2);
    end
    decline();
    chk_pos("drop_end_pos", 5, 3, 5, 6);
    quiet("drop_exit", 10);

    // steal wins over declined
    gametick = 1'b1;
    wait_req("steal_req");
    gametick = 1'b0;
    mv_steal = 1'b1;
    mv_declined = 1'b1;
    step(1);
    chk("steal_req_low", 32'(mv_request), 0);
    mv_steal = 1'b0;
    mv_declined = 1'b0;
    et = (m[2:0] == 3'd7) ? 3'd0 : m[2:0];
    step(1);
    chk("spawn_type", 32'(piece_type), 32'(et));
    chk("spawn_color", 32'(blk_color), 32'(et) + 1);
    chk_pos("spawn_pos", int'(et), 0, 5, 0);
    gametick = 1'b1;
    wait_req("spawn_tick_req");
    gametick = 1'b0;
    chk_pos("spawn_tick_pos", int'(et), 0, 5, 1);
    commit();
    step(2);

    // reset in the middle of a handshake
    gametick = 1'b1;
    wait_req("mid_req");
    gametick = 1'b0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("mid_rst_req", 32'(mv_request), 0);
    chk("mid_rst_type", 32'(piece_type), 5);
    chk_pos("mid_rst_pos", 5, 0, 5, 0);
    quiet("mid_rst_quiet", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
